// File: rtl/backscatter_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : backscatter_mod                                              |
// | Description : Backscatter symbol timer and FM0 / Miller-M line encoder.    |
// |               A free-running half-tick counter (hc) divides clk down to    |
// |               half-BLF ticks. A half-tick index (h) walks 0..2N-1 across   |
// |               each symbol, and the encoder drives the modulator level.     |
// |               Symbol parameters are latched at symbol start.               |
// | Ports       : clk, rst_n        - clock, asynchronous active-low reset     |
// |               i_clear_cu        - synchronous clear of timers and encoder  |
// |               i_half_div[7:0]   - clk per half BLF period (0,1,2 -> 2)     |
// |               i_m_dec[1:0]      - 00 FM0, 01 M2, 10 M4, 11 M8              |
// |               i_enable_mod      - transmit window                          |
// |               i_data_ocu        - bit to encode                            |
// |               i_violate_mod     - FM0 preamble violation marker            |
// |               i_mblf_mod        - pilot / subcarrier-only symbol           |
// |               o_datarate_ocu    - one-clk strobe in the last symbol clock  |
// |               o_mod_out         - modulator drive level                    |
// |               o_tx_active       - enable latched at current symbol start   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module backscatter_mod (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear_cu,
  input  logic [7:0] i_half_div,
  input  logic [1:0] i_m_dec,
  input  logic       i_enable_mod,
  input  logic       i_data_ocu,
  input  logic       i_violate_mod,
  input  logic       i_mblf_mod,
  output logic       o_datarate_ocu,
  output logic       o_mod_out,
  output logic       o_tx_active
);

  localparam logic [1:0] C_MODE_FM0 = 2'b00;

  // Timer state
  logic [7:0] hc_q, hc_d;
  logic [3:0] h_q, h_d;
  logic       init_q, init_d;         // first clock after reset release
  logic       sym_start_q, sym_start_d;
  logic       ht_q, ht_d;             // a half-tick happened in the previous clock

  // Encoder state
  logic       level_q, level_d;
  logic       b_q, b_d;
  logic       s_q, s_d;
  logic       p_q, p_d;

  // Bits latched at symbol start
  logic       bit_q, bit_d;
  logic       viol_q, viol_d;
  logic       mblf_q, mblf_d;
  logic       en_q, en_d;
  logic [1:0] mdec_q, mdec_d;

  // Combinational helpers
  logic [7:0] w_div_eff;
  logic [7:0] w_reload;
  logic [3:0] w_n_sym;
  logic [3:0] w_h_last;
  logic       w_half_tick;
  logic       w_strobe;
  logic       w_restart;
  logic       w_mid;
  logic       w_bit, w_viol, w_mblf, w_en;
  logic [1:0] w_mdec;

  // ---------------------------------------------------------------------------
  // Timers: hc counts clocks within a half BLF period, h counts half-ticks
  // within a symbol. Both free-run regardless of the enable.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_div_eff   = (i_half_div < 8'd2) ? 8'd2 : i_half_div;
    w_reload    = w_div_eff - 8'd1;
    w_n_sym     = 4'd1 << mdec_q;
    // 2N-1; for N=8 the 4-bit shift wraps to 0 and the subtraction yields 15.
    w_h_last    = (w_n_sym << 1) - 4'd1;
    w_half_tick = (hc_q == 8'd0);
    w_strobe    = w_half_tick && (h_q == w_h_last);
    // The first clock after reset release behaves like a clear so the first
    // symbol is a full one at the current divider and mode.
    w_restart   = i_clear_cu || init_q;

    hc_d        = hc_q;
    h_d         = h_q;
    init_d      = 1'b0;
    sym_start_d = w_restart || w_strobe;
    ht_d        = w_half_tick && !w_restart;

    if (w_restart) begin
      hc_d = w_reload;
      h_d  = 4'd0;
    end else if (w_half_tick) begin
      hc_d = w_reload;
      h_d  = w_strobe ? 4'd0 : (h_q + 4'd1);
    end else begin
      hc_d = hc_q - 8'd1;
    end
  end

  assign o_datarate_ocu = w_strobe;

  // ---------------------------------------------------------------------------
  // Encoder. All updates happen in the clock after a half-tick (ht_q) or in
  // the symbol-start clock, so every modulation edge lags its half-tick by one
  // clk. In the symbol-start clock the incoming inputs are used directly since
  // they are being latched on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    b_d     = b_q;
    s_d     = s_q;
    p_d     = p_q;
    bit_d   = bit_q;
    viol_d  = viol_q;
    mblf_d  = mblf_q;
    en_d    = en_q;
    mdec_d  = mdec_q;

    w_bit   = sym_start_q ? i_data_ocu    : bit_q;
    w_viol  = sym_start_q ? i_violate_mod : viol_q;
    w_mblf  = sym_start_q ? i_mblf_mod    : mblf_q;
    w_en    = sym_start_q ? i_enable_mod  : en_q;
    w_mdec  = sym_start_q ? i_m_dec       : mdec_q;

    // Mid-symbol point; h never equals N in a symbol-start clock.
    w_mid   = ht_q && !sym_start_q && (h_q == w_n_sym);

    if (sym_start_q) begin
      bit_d  = i_data_ocu;
      viol_d = i_violate_mod;
      mblf_d = i_mblf_mod;
      en_d   = i_enable_mod;
      mdec_d = i_m_dec;
    end

    if (!w_en) begin
      // Idle: park so the first enabled FM0 symbol starts at level 1 and the
      // first Miller symbol sees a previous bit of 1.
      level_d = 1'b0;
      b_d     = 1'b0;
      s_d     = 1'b0;
      p_d     = 1'b1;
    end else if (w_mdec == C_MODE_FM0) begin
      s_d = 1'b0;
      if (w_mblf) begin
        if (sym_start_q || ht_q) level_d = ~level_q;
      end else if (sym_start_q) begin
        level_d = ~level_q;
      end else if (w_mid && !w_bit && !w_viol) begin
        level_d = ~level_q;
      end
    end else begin
      if (ht_q) s_d = ~s_q;
      if (!w_mblf) begin
        if (sym_start_q) begin
          if (!w_bit && !p_q) b_d = ~b_q;
          p_d = w_bit;
        end else if (w_mid && w_bit) begin
          b_d = ~b_q;
        end
      end
    end

    // Clear wins over everything, including a coincident half-tick.
    if (i_clear_cu) begin
      level_d = 1'b0;
      b_d     = 1'b0;
      s_d     = 1'b0;
      p_d     = 1'b1;
      bit_d   = 1'b0;
      viol_d  = 1'b0;
      mblf_d  = 1'b0;
      en_d    = 1'b0;
      mdec_d  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q        <= 8'd1;
      h_q         <= 4'd0;
      init_q      <= 1'b1;
      sym_start_q <= 1'b0;
      ht_q        <= 1'b0;
      level_q     <= 1'b0;
      b_q         <= 1'b0;
      s_q         <= 1'b0;
      p_q         <= 1'b1;
      bit_q       <= 1'b0;
      viol_q      <= 1'b0;
      mblf_q      <= 1'b0;
      en_q        <= 1'b0;
      mdec_q      <= 2'b00;
    end else begin
      hc_q        <= hc_d;
      h_q         <= h_d;
      init_q      <= init_d;
      sym_start_q <= sym_start_d;
      ht_q        <= ht_d;
      level_q     <= level_d;
      b_q         <= b_d;
      s_q         <= s_d;
      p_q         <= p_d;
      bit_q       <= bit_d;
      viol_q      <= viol_d;
      mblf_q      <= mblf_d;
      en_q        <= en_d;
      mdec_q      <= mdec_d;
    end
  end

  // Subcarrier-only Miller symbols output s alone; FM0 drives the level.
  assign o_mod_out   = en_q && ((mdec_q == C_MODE_FM0) ? level_q
                                                       : (mblf_q ? s_q : (b_q ^ s_q)));
  assign o_tx_active = en_q;

endmodule
`default_nettype wire

// File: tb/tb_backscatter_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_backscatter_mod                                           |
// | Description : Self-checking bench for backscatter_mod. A reference model   |
// |               describes each symbol by its first-half / second-half line   |
// |               values and a running subcarrier; directed checks measure     |
// |               strobe periods, toggle counts and restart latency.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_backscatter_mod;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] hdiv = 8'd4;
  logic [1:0] mdec = 2'b00;
  logic       en = 1'b1;
  logic       dat = 1'b0;
  logic       viol = 1'b0;
  logic       mblf = 1'b0;
  logic       strobe;
  logic       mod_out;
  logic       tx_active;

  backscatter_mod dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear_cu     (clr),
    .i_half_div     (hdiv),
    .i_m_dec        (mdec),
    .i_enable_mod   (en),
    .i_data_ocu     (dat),
    .i_violate_mod  (viol),
    .i_mblf_mod     (mblf),
    .o_datarate_ocu (strobe),
    .o_mod_out      (mod_out),
    .o_tx_active    (tx_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_hc, m_h, m_mdec;
  bit m_init, m_ss, m_ht;
  bit m_lvl, m_lvl2, m_b, m_b2, m_s, m_p;
  bit m_bit, m_viol, m_mblf, m_en;

  function automatic int nsym(input int md);
    return 1 << md;
  endfunction

  task automatic enc_reset();
    m_lvl = 0; m_lvl2 = 0; m_b = 0; m_b2 = 0; m_s = 0; m_p = 1;
    m_bit = 0; m_viol = 0; m_mblf = 0; m_en = 0; m_mdec = 0;
  endtask

  task automatic model_reset();
    m_hc = 1; m_h = 0; m_init = 1; m_ss = 0; m_ht = 0;
    enc_reset();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_advance();
    int  div;
    bit  restart, strobe_now, new_ss, new_ht, old;
    div        = (hdiv < 8'd2) ? 2 : int'(hdiv);
    restart    = m_init || clr;
    strobe_now = (m_hc == 0) && (m_h == 2 * nsym(m_mdec) - 1);

    if (clr) begin
      enc_reset();
    end else if (m_ss) begin
      m_bit = dat; m_viol = viol; m_mblf = mblf; m_en = en; m_mdec = int'(mdec);
      if (!en) begin
        m_lvl = 0; m_b = 0; m_s = 0; m_p = 1;
      end else if (mdec == 2'b00) begin
        m_s   = 0;
        old   = m_lvl;
        m_lvl = !old;
        // Second half: a data-0 without violation flips back to the old level.
        m_lvl2 = (!dat && !viol) ? old : !old;
      end else begin
        if (m_ht) m_s = !m_s;
        if (!mblf) begin
          m_b  = m_b ^ (!dat && !m_p);
          m_b2 = m_b ^ dat;
          m_p  = dat;
        end
      end
    end else if (m_ht && m_en) begin
      if (m_mdec == 0) begin
        if (m_mblf) m_lvl = !m_lvl;
        else if (m_h == nsym(m_mdec)) m_lvl = m_lvl2;
      end else begin
        m_s = !m_s;
        if (!m_mblf && m_h == nsym(m_mdec)) m_b = m_b2;
      end
    end

    new_ss = restart || strobe_now;
    new_ht = (m_hc == 0) && !restart;
    if (restart) begin
      m_hc = div - 1; m_h = 0;
    end else if (m_hc == 0) begin
      m_hc = div - 1;
      m_h  = strobe_now ? 0 : m_h + 1;
    end else begin
      m_hc = m_hc - 1;
    end
    m_ss = new_ss; m_ht = new_ht; m_init = 0;
  endtask

  task automatic compare();
    bit e_strobe, e_mod;
    e_strobe = (m_hc == 0) && (m_h == 2 * nsym(m_mdec) - 1);
    if (!m_en)            e_mod = 0;
    else if (m_mdec == 0) e_mod = m_lvl;
    else if (m_mblf)      e_mod = m_s;
    else                  e_mod = m_b ^ m_s;
    check_eq("strobe", 32'(strobe), 32'(e_strobe));
    check_eq("mod_out", 32'(mod_out), 32'(e_mod));
    check_eq("tx_active", 32'(tx_active), 32'(m_en));
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input string tag);
    int i;
    i = 0;
    while (strobe !== 1'b1 && i < 200) begin
      step();
      i++;
    end
    if (strobe !== 1'b1) check_eq(tag, 32'(strobe), 32'd1);
  endtask

  task automatic period_check(input string tag, input int exp);
    int cnt;
    wait_strobe(tag);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (strobe !== 1'b1 && cnt < 200);
    check_eq(tag, 32'(cnt), 32'(exp));
  endtask

  // Count o_mod_out changes over the len clocks that follow a strobe.
  task automatic toggle_check(input string tag, input int len, input int exp, input bit viol_once);
    int  cnt;
    logic prev;
    wait_strobe(tag);
    if (viol_once) viol = 1'b1;
    cnt = 0;
    for (int i = 1; i <= len; i++) begin
      prev = mod_out;
      step();
      if (i == 2) viol = 1'b0;
      if (mod_out !== prev) cnt++;
    end
    check_eq(tag, 32'(cnt), 32'(exp));
  endtask

  // Abort mid-symbol by clear or reset and measure clocks to the next strobe.
  task automatic restart_check(input string tag, input bit use_reset, input int exp);
    int cnt;
    wait_strobe(tag);
    step(); step(); step();
    if (use_reset) begin
      do_reset();
      step();
    end else begin
      clr = 1'b1;
      step();
      clr = 1'b0;
    end
    cnt = 1;
    while (strobe !== 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    check_eq(tag, 32'(cnt), 32'(exp));
  endtask

  initial begin
    #1;
    do_reset();

    // FM0, div 4, data 1: 8-clk symbols, one transition each
    hdiv = 8'd4; mdec = 2'b00; en = 1'b1; dat = 1'b1;
    repeat (20) step();
    period_check("fm0_period", 8);
    toggle_check("fm0_d1_toggles", 8, 1, 1'b0);

    // FM0 data 0: transitions every 4 clk; a violated symbol has one
    dat = 1'b0;
    repeat (16) step();
    toggle_check("fm0_d0_toggles", 8, 2, 1'b0);
    toggle_check("fm0_viol_toggles", 8, 1, 1'b1);

    // Miller-2, div 3, bits 1,0,0 repeating
    hdiv = 8'd3; mdec = 2'b01;
    repeat (30) step();
    period_check("m2_period", 12);
    for (int k = 0; k < 6; k++) begin
      wait_strobe("m2_bits");
      dat = (k % 3 == 0);
      step();
      step();
    end

    // div 1 clamps to 2, Miller-8
    hdiv = 8'd1; mdec = 2'b11;
    repeat (40) step();
    period_check("m8_div1_period", 32);

    // Disabled output with clear and reset restarts
    en = 1'b0; hdiv = 8'd5; mdec = 2'b01;
    repeat (30) step();
    period_check("dis_period", 20);
    restart_check("clear_restart", 1'b0, 20);
    restart_check("reset_restart", 1'b1, 20);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      dat  = 1'($urandom);
      viol = ($urandom_range(0, 7) == 0);
      mblf = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 49) == 0) mdec = 2'($urandom);
      if ($urandom_range(0, 59) == 0) hdiv = 8'($urandom_range(0, 6));
      clr  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 499) == 0) begin
        clr = 1'b0;
        do_reset();
      end
      step();
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
